// File: rtl/m_countdown_ctrl.sv
// Countdown-timer controller: prescaled 1 s tick drives a two-digit BCD down-counter
// through IDLE/RUN/PAUSE/ALARM under one-cycle command pulses (priority rst>clr>stop>start>load_en).
module m_countdown_ctrl #(
    parameter int TICK_DIV  = 10000000,
    parameter int ALARM_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       load_en,
    input  logic [7:0] load_val,
    output logic [7:0] sec_bcd,
    output logic       tick,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [3:0]     ALARM_LAST = 4'(ALARM_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t          st;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_inc;
    logic [3:0]      alarm_cnt;

    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign presc_inc = (presc == PRESC_MAX) ? '0 : presc + PW'(1);
    assign tick      = (presc == PRESC_MAX) && ((st == RUN) || (st == ALARM));
    assign state     = st;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            st        <= IDLE;
            sec_bcd   <= 8'h00;
            presc     <= '0;
            alarm_cnt <= 4'd0;
            running   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    // stop has nothing to do here but still masks start/load_en
                    if (!stop && start) begin
                        if (sec_bcd != 8'h00) begin
                            st      <= RUN;
                            running <= 1'b1;
                            presc   <= '0;
                        end
                    end else if (!stop && load_en) begin
                        sec_bcd <= {clamp9(load_val[7:4]), clamp9(load_val[3:0])};
                    end
                end
                RUN: begin
                    // prescaler keeps counting on the stop edge; PAUSE then holds it
                    presc <= presc_inc;
                    if (stop) begin
                        st      <= PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        if (sec_bcd == 8'h01) begin
                            sec_bcd   <= 8'h00;
                            st        <= ALARM;
                            running   <= 1'b0;
                            alarm     <= 1'b1;
                            presc     <= '0;
                            alarm_cnt <= 4'd0;
                        end else begin
                            sec_bcd <= bcd_dec(sec_bcd);
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && start) begin
                        st      <= RUN;
                        running <= 1'b1;
                    end
                end
                ALARM: begin
                    presc <= presc_inc;
                    if (stop || (tick && alarm_cnt == ALARM_LAST)) begin
                        st        <= IDLE;
                        alarm     <= 1'b0;
                        sec_bcd   <= 8'h00;
                        presc     <= '0;
                        alarm_cnt <= 4'd0;
                    end else if (tick) begin
                        alarm_cnt <= alarm_cnt + 4'd1;
                    end
                end
                default: begin
                    st      <= IDLE;
                    running <= 1'b0;
                    alarm   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_countdown_ctrl.sv
// Directed bench for m_countdown_ctrl with TICK_DIV=4, ALARM_LEN=2.
module tb_m_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clr = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] sec_bcd;
    logic       tick;
    logic       running;
    logic       alarm;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    m_countdown_ctrl #(.TICK_DIV(4), .ALARM_LEN(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clr      (clr),
        .load_en  (load_en),
        .load_val (load_val),
        .sec_bcd  (sec_bcd),
        .tick     (tick),
        .running  (running),
        .alarm    (alarm),
        .state    (state)
    );

    always #5 clk = ~clk;

    // One clock: inputs set beforehand are sampled at this edge, then pulses drop.
    task automatic cyc();
        @(posedge clk);
        #1;
        rst = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0; load_en = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_sec [4] = '{8'h12, 8'h11, 8'h10, 8'h09};

    initial begin
        // reset state
        rst = 1'b1; cyc();
        chk("rst_state", 32'(state), 0);
        chk("rst_sec", 32'(sec_bcd), 32'h00);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_alarm", 32'(alarm), 0);

        // 12 -> 11 -> 10 -> 09, tick one cycle in four
        load_en = 1'b1; load_val = 8'h12; cyc();
        chk("load12", 32'(sec_bcd), 32'h12);
        start = 1'b1; cyc();
        chk("run_running", 32'(running), 1);
        chk("run_state", 32'(state), 1);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk($sformatf("run_tick_%0d", i), 32'(tick), ((i % 4) == 3) ? 1 : 0);
            if ((i % 4) == 0)
                chk($sformatf("run_sec_%0d", i), 32'(sec_bcd), 32'(exp_sec[i/4]));
        end

        // 02 -> ALARM after 8 clocks -> IDLE after 8 more
        clr = 1'b1; cyc();
        load_en = 1'b1; load_val = 8'h02; cyc();
        start = 1'b1; cyc();
        repeat (4) cyc();
        chk("a_sec01", 32'(sec_bcd), 32'h01);
        repeat (4) cyc();
        chk("a_sec00", 32'(sec_bcd), 32'h00);
        chk("a_alarm", 32'(alarm), 1);
        chk("a_state", 32'(state), 3);
        chk("a_running", 32'(running), 0);
        repeat (7) cyc();
        chk("a_still", 32'(state), 3);
        cyc();
        chk("a_done_state", 32'(state), 0);
        chk("a_done_alarm", 32'(alarm), 0);

        // pause keeps fractional second: stop at 2nd edge, resume finishes in 2
        load_en = 1'b1; load_val = 8'h05; cyc();
        start = 1'b1; cyc();
        cyc();
        stop = 1'b1; cyc();
        chk("p_state", 32'(state), 2);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) stop = 1'b1;
            cyc();
            if ((i % 5) == 4) begin
                chk($sformatf("p_sec_%0d", i), 32'(sec_bcd), 32'h05);
                chk($sformatf("p_st_%0d", i), 32'(state), 2);
            end
        end
        start = 1'b1; cyc();
        chk("p_resume", 32'(state), 1);
        cyc();
        chk("p_res_tick", 32'(tick), 1);
        chk("p_res_sec05", 32'(sec_bcd), 32'h05);
        cyc();
        chk("p_res_sec04", 32'(sec_bcd), 32'h04);

        // clamp, start at 00, load in RUN
        clr = 1'b1; cyc();
        load_en = 1'b1; load_val = 8'hAF; cyc();
        chk("clampAF", 32'(sec_bcd), 32'h99);
        clr = 1'b1; cyc();
        start = 1'b1; cyc();
        chk("start00", 32'(state), 0);
        load_en = 1'b1; load_val = 8'h12; cyc();
        start = 1'b1; cyc();
        load_en = 1'b1; load_val = 8'h34; cyc();
        chk("load_in_run", 32'(sec_bcd), 32'h12);

        // clr beats start in RUN
        clr = 1'b1; start = 1'b1; cyc();
        chk("clr_start_state", 32'(state), 0);
        chk("clr_start_sec", 32'(sec_bcd), 32'h00);

        // stop coincident with tick: no decrement, prescaler wraps to 0
        load_en = 1'b1; load_val = 8'h12; cyc();
        start = 1'b1; cyc();
        cyc(); cyc(); cyc();
        chk("st_tick_pre", 32'(tick), 1);
        stop = 1'b1; cyc();
        chk("st_tick_state", 32'(state), 2);
        chk("st_tick_sec", 32'(sec_bcd), 32'h12);
        start = 1'b1; cyc();
        cyc(); cyc(); cyc();
        chk("st_tick_sec_hold", 32'(sec_bcd), 32'h12);
        chk("st_tick_tick", 32'(tick), 1);
        cyc();
        chk("st_tick_sec_dec", 32'(sec_bcd), 32'h11);

        // rst during ALARM
        clr = 1'b1; cyc();
        load_en = 1'b1; load_val = 8'h01; cyc();
        start = 1'b1; cyc();
        repeat (4) cyc();
        chk("r_alarm_state", 32'(state), 3);
        cyc();
        rst = 1'b1; cyc();
        chk("r_state", 32'(state), 0);
        chk("r_sec", 32'(sec_bcd), 32'h00);
        chk("r_alarm", 32'(alarm), 0);
        chk("r_tick", 32'(tick), 0);
        load_en = 1'b1; load_val = 8'h03; cyc();
        start = 1'b1; cyc();
        cyc(); cyc();
        chk("r_tick_early", 32'(tick), 0);
        cyc();
        chk("r_tick_on", 32'(tick), 1);
        cyc();
        chk("r_sec02", 32'(sec_bcd), 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m_countdown_ctrl.md
# m_countdown_ctrl

Countdown-timer controller that sequences a prescaler and a two-digit BCD seconds counter through load, run, pause and alarm phases under one-cycle command pulses. It sits between the board's push-button pulse logic and the seconds display/decoder. It owns the prescaler enable, so the prescaler only advances while a countdown or alarm is active.

## Interface
- TICK_DIV, default 10000000: clocks per second tick; prescaler counts 0..TICK_DIV-1.
- ALARM_LEN, default 3: alarm duration in ticks, range 1..15.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse: begin or resume the countdown.
- stop  in  1  one-cycle pulse: pause the countdown, or cancel the alarm.
- clr  in  1  one-cycle pulse: abort to IDLE and zero the count.
- load_en  in  1  one-cycle pulse: load load_val; honoured in IDLE only.
- load_val  in  8  BCD preset; [7:4] tens, [3:0] units.
- sec_bcd  out  8  current count in BCD; [7:4] tens, [3:0] units.
- tick  out  1  one-cycle second strobe; active in RUN and ALARM only.
- running  out  1  high in RUN.
- alarm  out  1  high in ALARM.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.

## Operation
- Reset: state=IDLE, sec_bcd=8'h00, prescaler=0, alarm counter=0; tick=0, running=0, alarm=0.
- Command priority within one cycle: rst > clr > stop > start > load_en. Lower-priority commands in the same cycle are ignored.
- Prescaler:
  - Increments only in RUN and ALARM. Wraps at TICK_DIV-1.
  - tick = (prescaler==TICK_DIV-1) && state∈{RUN,ALARM}.
  - Held, not cleared, in PAUSE, so the fractional second is preserved.
  - Cleared by rst, clr, IDLE→RUN, and entry to ALARM.
- Load (IDLE only):
  - sec_bcd ← load_val, with each nibble >9 clamped to 9.
  - load_en in RUN, PAUSE or ALARM has no effect.
- IDLE:
  - start with sec_bcd≠00 → RUN.
  - start with sec_bcd=00 is ignored; state stays IDLE.
- RUN:
  - On tick, sec_bcd decrements by one in BCD: units 0 → 9 with tens-1; x0 borrow is correct, e.g. 10→09.
  - If sec_bcd is 01 at a tick: sec_bcd ← 00 and state → ALARM.
  - stop → PAUSE.
- PAUSE:
  - start → RUN.
  - stop is ignored.
  - sec_bcd is frozen.
- ALARM:
  - Alarm counter increments on each tick.
  - After ALARM_LEN ticks → IDLE, with sec_bcd=00.
  - stop → IDLE immediately.
- clr in any state: state=IDLE, sec_bcd=00, prescaler=0, alarm counter=0.
- sec_bcd never wraps below 00; no decrement occurs outside RUN.

## Timing
- All outputs except tick are registered. tick is combinational from registered state and prescaler.
- The sec_bcd update and any RUN→ALARM transition appear in the cycle after the edge that samples tick=1.
- Command latency: the state output changes one cycle after the command pulse.
- First tick after IDLE→RUN: TICK_DIV clocks after the start edge.
- After PAUSE→RUN: the remaining TICK_DIV-p clocks, where p is the prescaler value held in PAUSE.
- start and a tick in the same RUN cycle: the tick is processed normally (start is a no-op in RUN).
- stop in the same cycle as the tick that would decrement: stop wins. The state goes to PAUSE, sec_bcd is not decremented, and the prescaler wraps to 0.
- rst or clr mid-operation: the full reset state is reached on the next edge; an in-flight tick is discarded.

## Test plan
All scenarios use TICK_DIV=4, ALARM_LEN=2.
- Reset then load_val=8'h12, start → running=1 next cycle; sec_bcd reads 12, 11, 10, 09 at 4-clock intervals; tick high one cycle in every 4.
- Load 8'h02, start → after 8 clocks sec_bcd=00, alarm=1, state=3; after 8 more clocks state=0, alarm=0.
- Load 8'h05, start, stop 2 clocks into a second, wait 20 clocks, start → sec_bcd stays 05 throughout PAUSE; next decrement to 04 occurs 2 clocks after resume.
- Load 8'hAF → sec_bcd=8'h99. start with sec_bcd=00 → state stays 0. load_en asserted in RUN → sec_bcd unchanged.
- Simultaneous clr+start in RUN → state=0, sec_bcd=00. Simultaneous stop+tick → state=2, no decrement.
- Assert rst during ALARM → next cycle: state=0, sec_bcd=00, alarm=0, tick=0; prescaler restarts from 0 on the following start.
